// File: rtl/llc_vc_fifo.sv
// llc_vc_fifo
// -----------------------------------------------------------------------------
// NUM_CH independent circular queues that share one valid/ready output. A
// round-robin arbiter picks the output channel. Once a grant has been offered
// and stalled, the grant is locked until the handshake completes.
//
// Handshake semantics (all ports): a transfer happens on a rising clk_i edge
// where valid and ready are both 1. in_ready_o is derived only from registered
// counts and the flush inputs. out_valid_o is derived only from registered
// state, out_mask_i and the flush inputs. Neither depends on out_ready_i.
// Once out_valid_o is offered it stays up with stable out_ch_o/out_data_o
// until the transfer completes, unless the granted channel is flushed.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            flush every channel at the next edge
//   flush_ch_i[c]      flush channel c at the next edge
//   in_valid_i[c]      push request on channel c
//   in_ready_o[c]      channel c can take an entry this cycle
//   in_data_i[c]       payload for channel c
//   out_valid_o        granted channel has a head entry
//   out_ready_i        consumer takes the head entry
//   out_data_o         head payload of the granted channel
//   out_ch_o           granted channel index
//   out_mask_i[c]      channel c may win arbitration
//   usage_o[c]         entries held by channel c, 0..DEPTH
//   almost_full_o[c]   usage_o[c] >= AFULL_TH
//   empty_o[c]         usage_o[c] == 0
// -----------------------------------------------------------------------------
module llc_vc_fifo #(
  parameter int  NUM_CH     = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 4,
  parameter int  AFULL_TH   = DEPTH - 1,
  parameter type dtype      = logic [DATA_WIDTH-1:0],
  parameter int  CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int  CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [NUM_CH-1:0] flush_ch_i,
  input  logic [NUM_CH-1:0] in_valid_i,
  output logic [NUM_CH-1:0] in_ready_o,
  input  dtype              in_data_i [NUM_CH],
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output dtype              out_data_o,
  output logic [CH_W-1:0]   out_ch_o,
  input  logic [NUM_CH-1:0] out_mask_i,
  output logic [CNT_W-1:0]  usage_o [NUM_CH],
  output logic [NUM_CH-1:0] almost_full_o,
  output logic [NUM_CH-1:0] empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Per-channel state
  logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  dtype             mem_q    [NUM_CH][DEPTH];

  // Arbiter state
  logic [CH_W-1:0] rr_q;
  logic            lock_q;
  logic [CH_W-1:0] lock_ch_q;

  logic [NUM_CH-1:0] flush_any;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              rr_found;
  logic [CH_W-1:0]   rr_grant;
  logic [CH_W-1:0]   grant;
  logic              handshake;
  logic [CH_W-1:0]   next_rr;

  // Per-channel flags, all from registered counts
  always_comb begin
    flush_any     = '0;
    in_ready_o    = '0;
    push          = '0;
    eligible      = '0;
    empty_o       = '0;
    almost_full_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      usage_o[c]       = cnt_q[c];
      flush_any[c]     = flush_i | flush_ch_i[c];
      in_ready_o[c]    = (cnt_q[c] < DEPTH_C) & ~flush_any[c];
      push[c]          = in_valid_i[c] & in_ready_o[c];
      eligible[c]      = (cnt_q[c] != '0) & out_mask_i[c] & ~flush_any[c];
      empty_o[c]       = (cnt_q[c] == '0);
      almost_full_o[c] = (cnt_q[c] >= AFULL_C);
    end
  end

  // Round-robin search: first eligible channel at or after rr_q, with wrap
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_grant = CH_W'(idx);
      end
    end
  end

  // A locked grant ignores the mask; it only drops if its channel is flushed.
  // A locked channel always holds at least one entry.
  always_comb begin
    if (lock_q) begin
      grant       = lock_ch_q;
      out_valid_o = ~flush_any[lock_ch_q];
    end else begin
      grant       = rr_grant;
      out_valid_o = rr_found;
    end
    out_ch_o   = out_valid_o ? grant : '0;
    out_data_o = mem_q[grant][rd_ptr_q[grant]];
    handshake  = out_valid_o & out_ready_i;
    next_rr    = CH_W'((int'(grant) + 1) % NUM_CH);
    pop        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = handshake & (grant == CH_W'(c));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush_any[c]) begin
          rd_ptr_q[c] <= '0;
          wr_ptr_q[c] <= '0;
          cnt_q[c]    <= '0;
        end else begin
          if (push[c]) begin
            wr_ptr_q[c] <= (wr_ptr_q[c] == PTR_LAST) ? '0 : wr_ptr_q[c] + PTR_ONE;
          end
          if (pop[c]) begin
            rd_ptr_q[c] <= (rd_ptr_q[c] == PTR_LAST) ? '0 : rd_ptr_q[c] + PTR_ONE;
          end
          if (push[c] && !pop[c]) begin
            cnt_q[c] <= cnt_q[c] + CNT_ONE;
          end else if (pop[c] && !push[c]) begin
            cnt_q[c] <= cnt_q[c] - CNT_ONE;
          end
        end
      end

      if (handshake) begin
        rr_q <= next_rr;
      end

      // Stalled offer locks; a transfer, an idle cycle or a flushed lock clears.
      if (handshake) begin
        lock_q <= 1'b0;
      end else if (out_valid_o) begin
        lock_q    <= 1'b1;
        lock_ch_q <= grant;
      end else begin
        lock_q <= 1'b0;
      end
    end
  end

  // Storage carries no reset; flushed or stale entries are never read as valid.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_q[c][wr_ptr_q[c]] <= in_data_i[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push[g] |-> (cnt_q[g] != DEPTH_C))
      else $fatal(1, "push on full channel %0d", g);
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      pop[g] |-> (cnt_q[g] != '0))
      else $fatal(1, "pop on empty channel %0d", g);
  end

endmodule

// File: tb/tb_llc_vc_fifo.sv
// tb_llc_vc_fifo
// Bench for llc_vc_fifo: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-level model of
// the channels, the round-robin pointer and the stall lock.
module tb_llc_vc_fifo;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // main DUT (DEPTH=4)
  logic              flush_i;
  logic [NUM_CH-1:0] flush_ch_i, in_valid_i, in_ready_o, out_mask_i;
  logic [NUM_CH-1:0] almost_full_o, empty_o;
  logic [31:0]       in_data_i [NUM_CH];
  logic              out_valid_o, out_ready_i;
  logic [31:0]       out_data_o;
  logic [1:0]        out_ch_o;
  logic [2:0]        usage_o [NUM_CH];

  llc_vc_fifo dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flush_ch_i(flush_ch_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_mask_i(out_mask_i), .usage_o(usage_o),
    .almost_full_o(almost_full_o), .empty_o(empty_o)
  );

  // second DUT with non-power-of-2 depth for pointer wrap
  logic        w_flush;
  logic [1:0]  w_flush_ch, w_in_valid, w_in_ready, w_mask, w_afull, w_empty;
  logic [31:0] w_in_data [2];
  logic        w_out_valid, w_out_ready;
  logic [31:0] w_out_data;
  logic [0:0]  w_out_ch;
  logic [1:0]  w_usage [2];

  llc_vc_fifo #(.NUM_CH(2), .DEPTH(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(w_flush), .flush_ch_i(w_flush_ch),
    .in_valid_i(w_in_valid), .in_ready_o(w_in_ready), .in_data_i(w_in_data),
    .out_valid_o(w_out_valid), .out_ready_i(w_out_ready), .out_data_o(w_out_data),
    .out_ch_o(w_out_ch), .out_mask_i(w_mask), .usage_o(w_usage),
    .almost_full_o(w_afull), .empty_o(w_empty)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel is a list whose element 0 is the head.
  logic [31:0] mbuf [NUM_CH][DEPTH];
  int          msz  [NUM_CH];
  int          m_rr;
  bit          m_lock;
  int          m_lock_ch;

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) msz[c] = 0;
    m_rr = 0;
    m_lock = 1'b0;
    m_lock_ch = 0;
  endtask

  task automatic model_step();
    bit fl [NUM_CH];
    bit rdy [NUM_CH];
    bit gv;
    int gch;
    int c;
    for (int k = 0; k < NUM_CH; k++) begin
      fl[k]  = flush_i | flush_ch_i[k];
      rdy[k] = (msz[k] < DEPTH) && !fl[k];
      chk("in_ready", k, 64'(in_ready_o[k]), 64'(rdy[k]));
      chk("usage", k, 64'(usage_o[k]), 64'(msz[k]));
      chk("empty", k, 64'(empty_o[k]), 64'(msz[k] == 0));
      chk("almost_full", k, 64'(almost_full_o[k]), 64'(msz[k] >= AFULL));
    end
    gv = 1'b0;
    gch = 0;
    if (m_lock) begin
      gch = m_lock_ch;
      gv  = !fl[gch];
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        c = (m_rr + i) % NUM_CH;
        if (!gv && msz[c] > 0 && out_mask_i[c] && !fl[c]) begin
          gv = 1'b1;
          gch = c;
        end
      end
    end
    chk("out_valid", 0, 64'(out_valid_o), 64'(gv));
    if (gv) begin
      chk("out_ch", 0, 64'(out_ch_o), 64'(gch));
      chk("out_data", gch, 64'(out_data_o), 64'(mbuf[gch][0]));
    end
    // advance to the state after the coming edge
    if (gv && out_ready_i) begin
      for (int j = 0; j < DEPTH - 1; j++) mbuf[gch][j] = mbuf[gch][j+1];
      msz[gch]--;
      m_rr = (gch + 1) % NUM_CH;
      m_lock = 1'b0;
    end else begin
      m_lock = gv;
      m_lock_ch = gch;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (fl[k]) msz[k] = 0;
      else if (in_valid_i[k] && rdy[k]) begin
        mbuf[k][msz[k]] = in_data_i[k];
        msz[k]++;
      end
    end
  endtask

  // compare process: sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_out_valid", 0, 64'(out_valid_o), 64'd0);
      chk("rst_in_ready", 0, 64'(in_ready_o), 64'hF);
      chk("rst_empty", 0, 64'(empty_o), 64'hF);
      chk("rst_afull", 0, 64'(almost_full_o), 64'd0);
      chk("rst_out_ch", 0, 64'(out_ch_o), 64'd0);
      model_clear();
    end else begin
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0; flush_ch_i = '0; in_valid_i = '0; out_ready_i = 1'b0;
    out_mask_i = '1;
    for (int c = 0; c < NUM_CH; c++) in_data_i[c] = '0;
    w_flush = 1'b0; w_flush_ch = '0; w_in_valid = '0; w_out_ready = 1'b0;
    w_mask = '1; w_in_data[0] = '0; w_in_data[1] = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic random_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      in_valid_i[c] = ($urandom_range(0, 99) < 50);
      in_data_i[c]  = $urandom;
      out_mask_i[c] = ($urandom_range(0, 99) < 90);
      flush_ch_i[c] = ($urandom_range(0, 99) < 3);
    end
    flush_i     = ($urandom_range(0, 199) == 0);
    out_ready_i = ($urandom_range(0, 99) < 60);
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [31:0] v;

  initial begin
    idle();
    do_reset();

    // fill and drain ch1
    for (int k = 0; k <= 4; k++) begin
      in_valid_i[1] = (k < 4);
      in_data_i[1]  = 32'hA0 + 32'(k);
      @(negedge clk);
      chk("fill_usage", k, 64'(usage_o[1]), 64'(k));
      chk("fill_afull", k, 64'(almost_full_o[1]), 64'(k >= 3));
      chk("fill_ready", k, 64'(in_ready_o[1]), 64'(k < 4));
      tick();
    end
    in_valid_i = '0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_valid", k, 64'(out_valid_o), 64'd1);
      chk("drain_ch", k, 64'(out_ch_o), 64'd1);
      chk("drain_data", k, 64'(out_data_o), 64'(32'hA0 + 32'(k)));
      tick();
    end
    out_ready_i = 1'b0;
    @(negedge clk);
    chk("drain_done_valid", 0, 64'(out_valid_o), 64'd0);
    chk("drain_done_empty", 0, 64'(empty_o[1]), 64'd1);
    tick();

    // round-robin fairness
    do_reset();
    for (int k = 0; k < 2; k++) begin
      in_valid_i = '1;
      for (int c = 0; c < NUM_CH; c++) in_data_i[c] = 32'h100 * 32'(c) + 32'(k);
      tick();
    end
    in_valid_i = '0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_valid", i, 64'(out_valid_o), 64'd1);
      chk("rr_order", i, 64'(out_ch_o), 64'(exp_order[i]));
      tick();
    end
    @(negedge clk);
    chk("rr_done_valid", 0, 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b0;
    tick();

    // lock under backpressure, mask of the locked channel dropped
    do_reset();
    in_valid_i = 4'b1100;
    in_data_i[2] = 32'hC2;
    in_data_i[3] = 32'hC3;
    tick();
    in_valid_i = '0;
    for (int s = 0; s < 5; s++) begin
      out_mask_i[2] = (s < 1);
      @(negedge clk);
      chk("lock_ch", s, 64'(out_ch_o), 64'd2);
      chk("lock_data", s, 64'(out_data_o), 64'hC2);
      chk("lock_valid", s, 64'(out_valid_o), 64'd1);
      tick();
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("lock_release_ch", 0, 64'(out_ch_o), 64'd2);
    tick();
    @(negedge clk);
    chk("lock_next_ch", 0, 64'(out_ch_o), 64'd3);
    chk("lock_next_data", 0, 64'(out_data_o), 64'hC3);
    tick();
    out_ready_i = 1'b0;
    out_mask_i = '1;

    // flush of the locked channel with a concurrent push
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 4'b0010;
      in_data_i[1] = 32'hD0 + 32'(k);
      tick();
    end
    in_valid_i = 4'b0001;
    in_data_i[0] = 32'hE0;
    tick();
    in_valid_i = 4'b0010;
    in_data_i[1] = 32'hDF;
    flush_ch_i = 4'b0010;
    @(negedge clk);
    chk("flush_cycle_valid", 0, 64'(out_valid_o), 64'd0);
    chk("flush_cycle_usage", 1, 64'(usage_o[1]), 64'd3);
    tick();
    in_valid_i = '0;
    flush_ch_i = '0;
    @(negedge clk);
    chk("flush_usage", 1, 64'(usage_o[1]), 64'd0);
    chk("flush_empty", 1, 64'(empty_o[1]), 64'd1);
    chk("flush_valid", 0, 64'(out_valid_o), 64'd1);
    chk("flush_grant", 0, 64'(out_ch_o), 64'd0);
    chk("flush_data", 0, 64'(out_data_o), 64'hE0);
    tick();

    // asynchronous reset mid-operation
    do_reset();
    for (int k = 0; k < 2; k++) begin
      in_valid_i = 4'b0101;
      in_data_i[0] = 32'hF0 + 32'(k);
      in_data_i[2] = 32'hF2 + 32'(k);
      tick();
    end
    in_valid_i = '0;
    @(negedge clk);
    chk("pre_rst_valid", 0, 64'(out_valid_o), 64'd1);
    tick();
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 0, 64'(out_valid_o), 64'd0);
    chk("arst_ready", 0, 64'(in_ready_o), 64'hF);
    chk("arst_empty", 0, 64'(empty_o), 64'hF);
    chk("arst_afull", 0, 64'(almost_full_o), 64'd0);
    chk("arst_ch", 0, 64'(out_ch_o), 64'd0);
    for (int c = 0; c < NUM_CH; c++) chk("arst_usage", c, 64'(usage_o[c]), 64'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    out_ready_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("post_rst_valid", s, 64'(out_valid_o), 64'd0);
      chk("post_rst_usage0", s, 64'(usage_o[0]), 64'd0);
      tick();
    end
    out_ready_i = 1'b0;

    // pointer wrap with sustained push+pop on a depth-3 channel
    w_in_valid = 2'b01;
    v = $urandom;
    w_in_data[0] = v;
    @(negedge clk);
    chk("wrap_usage_start", 0, 64'(w_usage[0]), 64'd0);
    exp_q.push_back(v);
    tick();
    w_out_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      v = $urandom;
      w_in_data[0] = v;
      @(negedge clk);
      chk("wrap_usage", s, 64'(w_usage[0]), 64'd1);
      chk("wrap_valid", s, 64'(w_out_valid), 64'd1);
      chk("wrap_data", s, 64'(w_out_data), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      exp_q.push_back(v);
      tick();
    end
    w_in_valid = '0;
    @(negedge clk);
    chk("wrap_last_data", 0, 64'(w_out_data), 64'(exp_q[0]));
    void'(exp_q.pop_front());
    tick();
    w_out_ready = 1'b0;
    @(negedge clk);
    chk("wrap_end_usage", 0, 64'(w_usage[0]), 64'd0);
    chk("wrap_end_valid", 0, 64'(w_out_valid), 64'd0);
    tick();

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      tick();
    end
    idle();
    out_ready_i = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
